rv32i_mem_access: RTL

RV32I_MEM_ACCESS -- requirements
Module: rv32i_mem_access

---
 rtl/rv32i_mem_access.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rv32i_mem_access.sv
// rv32i_mem_access: load/store unit that connects the ALU stage to a
// pipelined, wait-stated memory bus. It runs one transaction at a time.
// The stage sequence is IDLE -> REQ -> (RDWAIT) -> IDLE.
// Build option RV32I_MEM_TIMEOUT_EN adds an abort timer. The timer aborts
// a bus transaction that is still open after TIMEOUT_CYCLES cycles, and
// then pulses bus_error. Without the option, a transaction waits for as
// long as the bus takes.
module rv32i_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alu_load,
  input  logic        alu_store,
  input  logic [31:0] alu_addr,
  input  logic [3:0]  alu_be,
  input  logic [31:0] alu_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        stall,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t state, next_state;
  logic   op_store;   // latched op; a store wins when both requests are high
  logic   accept;     // IDLE takes a new request this cycle
  logic   busy;       // a transaction is open on the bus
  logic   complete;   // the open transaction finishes this cycle
  logic   abort;      // the timer kills the open transaction this cycle
  logic   load_end;   // a load ends this cycle, by data or by abort

  // A timer limit outside 1..255 has no meaning for the 8-bit counter.
  // A bad setting therefore appears as this named scope in the hierarchy.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_timeout_cycles_out_of_range
  end

  // State register; reset abandons any open transaction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = REQ;
      REQ: begin
        if (complete || abort)                   next_state = IDLE;
        else if (!op_store && !mem_waitrequest)  next_state = RDWAIT;
      end
      RDWAIT:  if (complete || abort) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output/decode logic: command strobes and the completion condition
  always_comb begin
    accept    = 1'b0;
    complete  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (state)
      IDLE:    accept = alu_load | alu_store;
      REQ: begin
        mem_read  = ~op_store;
        mem_write = op_store;
        // A store ends once it is accepted. A load can also end in the same
        // cycle, if the read data returns together with the acceptance.
        complete  = ~mem_waitrequest & (op_store | mem_readdatavalid);
      end
      RDWAIT:  complete = mem_readdatavalid;
      default: ;
    endcase
  end

  assign busy     = (state != IDLE);
  assign load_end = (complete | abort) & ~op_store;
  // The pipeline is held from the accept cycle onward. It is released in
  // the cycle that ends the transaction, so the ALU can issue again.
  assign stall    = accept | (busy & ~complete & ~abort);

  // Command capture at accept; the bus fields stay stable until the next accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr       <= '0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
      op_store       <= 1'b0;
    end else if (accept) begin
      mem_addr       <= alu_addr;
      mem_byteenable <= alu_be;
      mem_writedata  <= alu_wdata;
      op_store       <= alu_store;
    end
  end

  // Load return: a one-cycle ld_valid pulse; ld_data holds until the next load ends
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_data  <= '0;
      ld_valid <= 1'b0;
    end else begin
      ld_valid <= load_end;
      if (complete && !op_store)  ld_data <= mem_readdata;
      else if (load_end)          ld_data <= '0;
    end
  end

`ifdef RV32I_MEM_TIMEOUT_EN
  localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;

  // Count the bus cycles that end without completion. The count restarts at each accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                wait_cnt <= '0;
    else if (accept)             wait_cnt <= '0;
    else if (busy && !complete)  wait_cnt <= wait_cnt + 8'd1;
  end

  // The final open cycle that does not complete becomes the abort cycle
  assign abort = busy & ~complete & (wait_cnt == LAST_CYCLE);

  // bus_error pulses together with the ld_valid of an aborted load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus_error <= 1'b0;
    else          bus_error <= abort;
  end
`else
  assign abort     = 1'b0;
  assign bus_error = 1'b0;
`endif

endmodule
